// File: rtl/bs_mult_pkg.sv
// Shared types and constants for the bit-serial multiplier (bs_mult_serial).
package bs_mult_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/bs_mult_step.sv
// One serial multiply step: folds bit k of x/y into the running accumulator.
module bs_mult_step
  import bs_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic               x_i,
  input  logic               y_i,
  input  logic [WIDTH-1:0]   xs_i,
  input  logic [WIDTH-1:0]   ys_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [CW-1:0]      k_i,
  output logic               p_o,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0]   ybit;
  logic [WIDTH-1:0]   ymask;
  logic [2*WIDTH:0]   t;

  always_comb begin
    ybit  = {{(WIDTH-1){1'b0}}, y_i} << k_i;
    ymask = ys_i | ybit;
    t     = {1'b0, acc_i}
          + (x_i ? {{(WIDTH+1){1'b0}}, ymask} : '0)
          + (y_i ? {{(WIDTH+1){1'b0}}, xs_i}  : '0);
    p_o   = t[0];
    acc_o = t[2*WIDTH:1];
  end

endmodule

// File: rtl/bs_mult_serial.sv
// LSB-first bit-serial multiplier, truncated WIDTH-bit product on p.
// Optional signed-overflow flag ovf enabled by defining BS_MULT_OVF_EN.
module bs_mult_serial
  import bs_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic y,
  input  logic firstbit,
  input  logic lastbit,
`ifdef BS_MULT_OVF_EN
  output logic ovf,
`endif
  output logic p
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] KMAX = CW'(WIDTH - 1);

  state_e               state_q;
  logic [CW-1:0]        cnt_q, k_d;
  logic [WIDTH-1:0]     xs_q, ys_q, xs_d, ys_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_in;
  logic                 p_q, p_d;
  logic                 in_frame;
  logic [WIDTH-1:0]     xbit, ybit;

  // A firstbit sample discards all history so a mid-frame restart starts clean.
  always_comb begin
    in_frame = firstbit || (state_q == RUN);
    k_d      = firstbit ? '0 : cnt_q;
    acc_in   = firstbit ? '0 : acc_q;
    xbit     = {{(WIDTH-1){1'b0}}, x} << k_d;
    ybit     = {{(WIDTH-1){1'b0}}, y} << k_d;
    xs_d     = (firstbit ? '0 : xs_q) | xbit;
    ys_d     = (firstbit ? '0 : ys_q) | ybit;
  end

  bs_mult_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
    .x_i   (x),
    .y_i   (y),
    .xs_i  (firstbit ? '0 : xs_q),
    .ys_i  (firstbit ? '0 : ys_q),
    .acc_i (acc_in),
    .k_i   (k_d),
    .p_o   (p_d),
    .acc_o (acc_d)
  );

`ifdef BS_MULT_OVF_EN
  logic signed [2*WIDTH-1:0] full;
  logic                      ovf_d, ovf_q;

  always_comb begin
    full  = $signed(xs_d) * $signed(ys_d);
    ovf_d = !((&full[2*WIDTH-1:WIDTH-1]) || !(|full[2*WIDTH-1:WIDTH-1]));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      acc_q   <= '0;
      p_q     <= 1'b0;
`ifdef BS_MULT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else if (in_frame) begin
      p_q     <= p_d;
      acc_q   <= acc_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      cnt_q   <= (k_d == KMAX) ? k_d : k_d + 1'b1;
      state_q <= lastbit ? IDLE : RUN;
`ifdef BS_MULT_OVF_EN
      ovf_q   <= lastbit & ovf_d;
`endif
    end else begin
      p_q     <= 1'b0;
`ifdef BS_MULT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end
  end

  assign p = p_q;
`ifdef BS_MULT_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bs_mult_serial.sv
// Scoreboard bench for bs_mult_serial (WIDTH=16); checks ovf when BS_MULT_OVF_EN is defined.
module tb_bs_mult_serial;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic p;
    logic o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0, y = 1'b0, firstbit = 1'b0, lastbit = 1'b0;
  logic p;
`ifdef BS_MULT_OVF_EN
  logic ovf;
`endif

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  bs_mult_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .firstbit (firstbit),
    .lastbit  (lastbit),
`ifdef BS_MULT_OVF_EN
    .ovf      (ovf),
`endif
    .p        (p)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lo_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] f;
    f = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return f[W-1:0];
  endfunction

  function automatic logic sovf(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, pr, lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pr = sa * sb;
    lo = longint'($signed(pr[W-1:0]));
    return pr != lo;
  endfunction

  // One clock: drive inputs, push the expectation, compare after the edge.
  task automatic cyc(input logic xb, input logic yb, input logic fb, input logic lb,
                     input logic ep, input logic eo, input string nm, output logic got);
    exp_t e;
    x = xb; y = yb; firstbit = fb; lastbit = lb;
    exp_q.push_back('{p: ep, o: eo});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got = p;
    checks++;
    if (p !== e.p) begin
      errors++;
      $display("FAIL %s p: got %b want %b (t=%0t)", nm, p, e.p, $time);
    end
`ifdef BS_MULT_OVF_EN
    checks++;
    if (ovf !== e.o) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b (t=%0t)", nm, ovf, e.o, $time);
    end
`endif
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input string nm, output logic [W-1:0] seen);
    logic [W-1:0] lo;
    logic         o, g;
    lo = lo_prod(a, b);
    o  = sovf(a, b);
    for (int i = 0; i < int'(W); i++) begin
      cyc(a[i], b[i], i == 0, i == int'(W) - 1, lo[i], (i == int'(W) - 1) ? o : 1'b0, nm, g);
      seen[i] = g;
    end
  endtask

  task automatic idle_cycles(input int n, input string nm);
    logic g;
    for (int i = 0; i < n; i++)
      cyc(1'($urandom), 1'($urandom), 1'b0, (i == n / 2), 1'b0, 1'b0, nm, g);
  endtask

  task automatic test_reset;
    logic g;
    rst_n = 1'b0;
    #12;
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL reset_init p: got %b want 0", p); end
    @(negedge clk); rst_n = 1'b1;
    // 0x00FF*0x00FF = 0xFE01: bit0 is 1, so reset has something to clear.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "reset_pre", g);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_pre", g);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_pre", g);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL reset_async p: got %b want 0", p); end
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(6, "reset_after");
  endtask

  task automatic test_directed;
    logic [W-1:0] seen;
    logic         g;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "stray_last", g);
    send_word(16'hFFFE, 16'h0003, "dir_fffe_3", seen);
    checks++;
    if (seen !== 16'hFFFA) begin
      errors++; $display("FAIL dir_word: got %h want fffa", seen);
    end
    send_word(16'h00FF, 16'h0101, "dir_ff_101", seen);
    checks++;
    if (seen !== 16'hFFFF) begin
      errors++; $display("FAIL dir_word2: got %h want ffff", seen);
    end
    send_word(16'h8000, 16'h0002, "dir_8000_2", seen);
    idle_cycles(2, "dir_gap");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] s1, s2;
    send_word(16'h0003, 16'h0005, "b2b_a", s1);
    send_word(16'h7FFF, 16'h7FFF, "b2b_b", s2);
    checks++;
    if (s1 !== 16'h000F || s2 !== 16'h0001) begin
      errors++; $display("FAIL b2b_words: got %h,%h want 000f,0001", s1, s2);
    end
    idle_cycles(2, "b2b_gap");
  endtask

  task automatic test_restart;
    logic [W-1:0] a, b, lo, seen;
    logic         g;
    a = 16'hBEEF; b = 16'h1234;
    lo = lo_prod(a, b);
    for (int i = 0; i < 7; i++)
      cyc(a[i], b[i], i == 0, 1'b0, lo[i], 1'b0, "restart_part", g);
    send_word(16'h0123, 16'h0456, "restart_new", seen);
    for (int r = 0; r < 4; r++) begin
      a = 16'($urandom); b = 16'($urandom);
      send_word(a, b, "rand_word", seen);
    end
    // One-bit word: firstbit and lastbit together.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "one_bit", g);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "one_bit_after", g);
  endtask

  task automatic test_idle;
    idle_cycles(20, "idle");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_restart;
    test_idle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bs_mult_serial.md
Name: bs_mult_serial

Overview:
- LSB-first bit-serial multiplier for two WIDTH-bit operands x and y streamed one bit per clock.
- Emits the WIDTH-bit truncated product serially on p, LSB first, one cycle behind the input bits.
- Word framing comes from firstbit (marks bit 0) and lastbit (marks bit WIDTH-1).
- Sits in bit-serial datapaths (e.g. serial MAC/filter lanes) between serializers and serial adders.

Parameters:
- WIDTH, 16, operand and product word length in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- x  input  1  serial operand X bit, LSB first
- y  input  1  serial operand Y bit, LSB first
- firstbit  input  1  high on the cycle carrying bit 0 of x/y
- lastbit  input  1  high on the cycle carrying bit WIDTH-1; may also pulse outside a frame (ignored)
- p  output  1  registered serial product bit, LSB first

Behaviour:
- Reset: asynchronous on rst_n low. p=0; operand shift registers, accumulator and bit counter cleared; state idle.
- All inputs are sampled on rising clk. A sample taken while firstbit=1 is bit 0 and starts a frame.
- firstbit=1 mid-frame aborts the current frame and restarts with that sample as bit 0. The partial result is discarded.
- Per sampled bit k (x_k, y_k), with X[k-1:0] and Y[k-1:0] holding earlier bits:
  - t = acc + x_k*Y[k:0] + y_k*X[k-1:0]; on bit 0, acc is taken as 0.
  - p <= t[0]; acc <= t>>1.
  - acc width: 2*WIDTH bits, no overflow possible.
- Latency: the edge sampling bit k updates p to product bit k. p holds that value for one cycle.
- Result: bits 0..WIDTH-1 on p equal (X*Y) mod 2^WIDTH, identical for signed and unsigned operands.
- A sample with lastbit=1 inside a frame is the final bit. It produces product bit WIDTH-1, then the block returns to idle.
- Idle: p <= 0 on every edge; x and y are ignored. lastbit outside a frame has no effect.
- firstbit and lastbit high together: a one-bit word (bit 0 only). Restart precedence applies, then the frame ends.
- Frame runs past WIDTH bits without lastbit: the bit counter saturates at WIDTH-1 and further bits keep updating p as above. No error is flagged.
- Back-to-back frames are supported: firstbit may be high on the cycle right after the lastbit sample.

Optional Feature:
- Macro BS_MULT_OVF_EN.
- Defined:
  - Extra output ovf (1 bit, reset 0), registered.
  - Asserted for exactly one cycle, coincident with p carrying product bit WIDTH-1.
  - Asserted when the full signed product of the WIDTH-bit X and Y does not equal the sign-extension of its low WIDTH bits.
  - Cleared on all other cycles.
- Not defined: no ovf port and no full-product logic.

Decomposition:
- Package bs_mult_pkg:
  - WIDTH default constant.
  - Frame state enum (IDLE, RUN).
  - Counter width localparam $clog2(WIDTH).
- Natural sub-module: bs_mult_step.
  - Combinational: takes x_k, y_k, X, Y, acc, k; produces t[0] and the next acc.
  - Top keeps registers, framing FSM and optional ovf.

Test Plan:
- Reset: rst_n low mid-frame -> p=0 immediately; no output bits until the next firstbit.
- Directed, WIDTH=16, x=0xFFFE, y=0x0003:
  - Stimulus: lastbit pulse one cycle before firstbit; x bits 0,1,1,..,1; y bits 1,1,0,..,0; lastbit with bit 15.
  - Required p sequence (one cycle behind): 0,1,0,1,1,1,1,1,1,1,1,1,1,1,1,1, i.e. 0xFFFA (-6). ovf=0.
- 0x00FF*0x0101 -> p streams 0xFFFF. 0x8000*0x0002 -> p streams 0x0000, ovf=1 when enabled.
- Back-to-back: 0x0003*0x0005 then immediately 0x7FFF*0x7FFF -> 0x000F then 0x0001 (ovf=1 when enabled). No idle gap between output words.
- firstbit reasserted at bit 7 of a frame -> new frame restarts; output equals the new word's product only.
- Idle: random x/y with no firstbit and a stray lastbit -> p stays 0.
